// File: rtl/aes_pkg.sv
// Shared AES types, round constants and word helpers.
// Used by the inverse key schedule and the forward key expansion.
package aes_pkg;

  typedef logic [31:0] word_t;
  typedef logic [127:0] block_t;

  typedef enum logic [1:0] {
    IDLE,
    EMIT,
    FINISH
  } state_t;

  // Indexed by round number; entries past 10 are never selected.
  localparam logic [7:0] RCON [16] = '{
    8'h00, 8'h01, 8'h02, 8'h04,
    8'h08, 8'h10, 8'h20, 8'h40,
    8'h80, 8'h1b, 8'h36, 8'h00,
    8'h00, 8'h00, 8'h00, 8'h00
  };

  function automatic word_t rot_word(input word_t w);
    return {w[23:0], w[31:24]};
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES byte S-box: GF(2^8) inverse then affine map.
// Shared between forward and inverse key schedules.
module aes_sbox (
  input  logic [7:0] data,
  output logic [7:0] sub
);

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  logic [7:0] inv;
  logic [7:0] sq;

  // x^254 is the multiplicative inverse (and maps 0 to 0).
  always_comb begin
    inv = 8'h01;
    sq  = data;
    for (int i = 1; i < 8; i++) begin
      sq  = gmul(sq, sq);
      inv = gmul(inv, sq);
    end
  end

  assign sub = inv
             ^ {inv[6:0], inv[7]}
             ^ {inv[5:0], inv[7:6]}
             ^ {inv[4:0], inv[7:5]}
             ^ {inv[3:0], inv[7:4]}
             ^ 8'h63;

endmodule

// File: rtl/aes_inv_key_schedule.sv
// Iterative AES-128 inverse key schedule: emits round keys 10 down to 0.
// Define AES_INV_KS_CACHE_EN to keep a readable copy of all 11 keys.
module aes_inv_key_schedule
  import aes_pkg::*;
#(
  parameter int NROUNDS = 10
) (
  input  logic         clk,
  input  logic         nreset,
  input  logic         load,
  input  logic [127:0] key_last,
  input  logic         key_ready,
  output logic [127:0] round_key,
  output logic [3:0]   round_idx,
  output logic         key_valid,
  output logic         busy,
`ifdef AES_INV_KS_CACHE_EN
  input  logic [3:0]   rd_idx,
  output logic [127:0] rd_key,
  output logic         cache_valid,
`endif
  output logic         done
);

  if (NROUNDS != 10) begin : g_bad_rounds
    $error("aes_inv_key_schedule supports AES-128 only (NROUNDS=10)");
  end

  state_t state;
  state_t state_next;
  block_t key;
  block_t key_next;
  logic [3:0] idx;
  logic [3:0] idx_next;

  word_t k0, k1, k2, k3;
  word_t p0, p1, p2, p3;
  word_t rot;
  word_t sub;
  block_t prev;

  assign {k0, k1, k2, k3} = key;
  assign p3  = k3 ^ k2;
  assign p2  = k2 ^ k1;
  assign p1  = k1 ^ k0;
  assign rot = rot_word(p3);

  for (genvar i = 0; i < 4; i++) begin : g_sbox
    aes_sbox u_sbox (
      .data (rot[8*i +: 8]),
      .sub  (sub[8*i +: 8])
    );
  end

  assign p0   = k0 ^ sub ^ {RCON[idx], 24'h0};
  assign prev = {p0, p1, p2, p3};

  logic step;
  assign step = (state == EMIT) && key_ready;

  always_comb begin
    state_next = state;
    key_next   = key;
    idx_next   = idx;
    if (load) begin
      state_next = EMIT;
      key_next   = key_last;
      idx_next   = 4'(NROUNDS);
    end else begin
      unique case (state)
        IDLE: ;
        EMIT: begin
          if (step) begin
            if (idx != 4'd0) begin
              key_next = prev;
              idx_next = idx - 4'd1;
            end else begin
              state_next = FINISH;
            end
          end
        end
        FINISH:  state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      state <= IDLE;
      key   <= '0;
      idx   <= '0;
    end else begin
      state <= state_next;
      key   <= key_next;
      idx   <= idx_next;
    end
  end

  assign round_key = key;
  assign round_idx = idx;
  assign key_valid = (state == EMIT);
  assign busy      = (state != IDLE);
  assign done      = (state == FINISH);

`ifdef AES_INV_KS_CACHE_EN
  block_t mem [0:10];

  // Rewriting the held key on a stall stores the same value.
  always_ff @(posedge clk) begin
    if (state == EMIT && idx <= 4'd10) mem[idx] <= key;
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      rd_key      <= '0;
      cache_valid <= 1'b0;
    end else begin
      rd_key <= (rd_idx > 4'd10) ? '0 : mem[rd_idx];
      if (load)                 cache_valid <= 1'b0;
      else if (state == FINISH) cache_valid <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_aes_inv_key_schedule.sv
// Randomized scoreboard bench for aes_inv_key_schedule.
// Reference derives keys from the FIPS-197 word-array recurrence.
module tb_aes_inv_key_schedule;

  localparam logic [127:0] FIPS10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] FIPS9  = 128'hac7766f319fadc2128d12941575c006e;
  localparam logic [127:0] FIPS0  = 128'h2b7e151628aed2a6abf7158809cf4f3c;

  typedef struct packed {
    logic [127:0] key;
    logic [3:0]   idx;
  } exp_t;

  logic         clk;
  logic         nreset;
  logic         load;
  logic [127:0] key_last;
  logic         key_ready;
  logic [127:0] round_key;
  logic [3:0]   round_idx;
  logic         key_valid;
  logic         busy;
  logic         done;
`ifdef AES_INV_KS_CACHE_EN
  logic [3:0]   rd_idx;
  logic [127:0] rd_key;
  logic         cache_valid;
`endif

  aes_inv_key_schedule dut (
    .clk       (clk),
    .nreset    (nreset),
    .load      (load),
    .key_last  (key_last),
    .key_ready (key_ready),
    .round_key (round_key),
    .round_idx (round_idx),
    .key_valid (key_valid),
    .busy      (busy),
`ifdef AES_INV_KS_CACHE_EN
    .rd_idx      (rd_idx),
    .rd_key      (rd_key),
    .cache_valid (cache_valid),
`endif
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [127:0] act,
                     input logic [127:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Reference S-box and Rcon built from GF(2^8) log tables.
  logic [7:0] sb [256];
  logic [7:0] rc [11];

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  task automatic build_tables();
    logic [7:0] ex [256];
    int lg [256];
    logic [7:0] inv;
    logic [7:0] s;
    logic [7:0] c;
    c = 8'h63;
    ex[0] = 8'h01;
    lg[1] = 0;
    for (int i = 1; i < 255; i++) begin
      ex[i] = ex[i-1] ^ xt(ex[i-1]);
      lg[ex[i]] = i;
    end
    for (int x = 0; x < 256; x++) begin
      inv = (x == 0) ? 8'h00 : ex[(255 - lg[x]) % 255];
      for (int b = 0; b < 8; b++)
        s[b] = inv[b] ^ inv[(b+4)%8] ^ inv[(b+5)%8]
             ^ inv[(b+6)%8] ^ inv[(b+7)%8] ^ c[b];
      sb[x] = s;
    end
    rc[0] = 8'h00;
    rc[1] = 8'h01;
    for (int i = 2; i < 11; i++) rc[i] = xt(rc[i-1]);
  endtask

  exp_t pend[$];
  exp_t cur[$];
  logic [127:0] pend_key;
  logic [127:0] walk_key;

  // Undo w[i+4] = w[i] ^ f(w[i+3]) from the last four words downwards.
  task automatic build_expect(input logic [127:0] k);
    logic [31:0] w [44];
    logic [31:0] t;
    exp_t e;
    for (int i = 0; i < 4; i++) w[40+i] = k[127-32*i -: 32];
    for (int i = 39; i >= 0; i--) begin
      t = w[i+3];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
        t = t ^ {rc[(i+4)/4], 24'h0};
      end
      w[i] = w[i+4] ^ t;
    end
    pend.delete();
    for (int r = 10; r >= 0; r--) begin
      e.key = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
      e.idx = 4'(r);
      pend.push_back(e);
    end
    pend_key = k;
  endtask

  logic exp_done = 1'b0;
  logic exp_zero = 1'b1;
  logic nd;

  always @(negedge clk) begin
    nd = 1'b0;
    chk("done", {127'd0, done}, {127'd0, exp_done});
    chk("key_valid", {127'd0, key_valid}, {127'd0, cur.size() != 0});
    chk("busy", {127'd0, busy}, {127'd0, (cur.size() != 0) || exp_done});
    if (exp_zero) begin
      chk("reset_key", round_key, '0);
      chk("reset_idx", {124'd0, round_idx}, '0);
      exp_zero = 1'b0;
    end
    if (key_valid && cur.size() != 0) begin
      chk("round_key", round_key, cur[0].key);
      chk("round_idx", {124'd0, round_idx}, {124'd0, cur[0].idx});
      if (walk_key == FIPS10 && round_idx == 4'd9)
        chk("fips_idx9", round_key, FIPS9);
      if (walk_key == FIPS10 && round_idx == 4'd0)
        chk("fips_idx0", round_key, FIPS0);
      if (key_ready) begin
        if (cur[0].idx == 4'd0) nd = 1'b1;
        void'(cur.pop_front());
      end
    end
    if (!nreset) begin
      cur.delete();
      nd = 1'b0;
      exp_zero = 1'b1;
    end else if (load) begin
      cur = pend;
      walk_key = pend_key;
      nd = 1'b0;
    end
    exp_done = nd;
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [127:0] k);
    build_expect(k);
    load = 1'b1;
    key_last = k;
    cyc(1);
    load = 1'b0;
    key_last = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic wait_idle(input bit rnd);
    int n;
    n = 0;
    while (busy && n < 400) begin
      if (rnd) key_ready = ($urandom_range(0, 3) != 0);
      cyc(1);
      n++;
    end
    checks++;
    if (busy) begin
      failures++;
      $display("FAIL walk_timeout actual=busy required=idle");
    end
    key_ready = 1'b1;
    cyc(1);
  endtask

  function automatic logic [127:0] rkey();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    nreset = 1'b0;
    load = 1'b0;
    key_ready = 1'b0;
    key_last = '0;
`ifdef AES_INV_KS_CACHE_EN
    rd_idx = '0;
`endif
    build_tables();
    cyc(3);
    nreset = 1'b1;
    cyc(1);

    key_ready = 1'b1;
    do_load(FIPS10);
    wait_idle(1'b0);

`ifdef AES_INV_KS_CACHE_EN
    rd_idx = 4'd0;
    cyc(1);
    chk("rd_idx0", rd_key, FIPS0);
    rd_idx = 4'd10;
    cyc(1);
    chk("rd_idx10", rd_key, FIPS10);
    rd_idx = 4'd12;
    cyc(1);
    chk("rd_idx12", rd_key, '0);
    chk("cache_valid", {127'd0, cache_valid}, 128'd1);
`endif

    do_load(FIPS10);
    cyc(3);
    key_ready = 1'b0;
    cyc(3);
    key_ready = 1'b1;
    wait_idle(1'b0);

    do_load(rkey());
    cyc(6);
    do_load(rkey());
    wait_idle(1'b0);

    do_load(rkey());
    cyc(4);
    nreset = 1'b0;
    cyc(1);
    nreset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      key_ready = i[0];
      cyc(1);
    end

    key_ready = 1'b1;
    do_load(rkey());
    cyc(10);
    do_load(rkey());
    wait_idle(1'b0);

    for (int w = 0; w < 6; w++) begin
      do_load(rkey());
      wait_idle(1'b1);
    end

    cyc(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
